// File: rtl/cnn_cfg_defs.sv
// Shared CNN datapath definitions: cfg bus map, lane math, stage states.
// Used by the pooling and upsampling stages.
package cnn_cfg_defs;

  localparam logic [5:0] CFG_POOL_KH    = 6'h20;
  localparam logic [5:0] CFG_POOL_KW    = 6'h21;
  localparam logic [5:0] CFG_POOL_STR   = 6'h22;
  localparam logic [5:0] CFG_POOL_ROW_W = 6'h23;
  localparam logic [5:0] CFG_UP_SCALE_H = 6'h24;
  localparam logic [5:0] CFG_UP_SCALE_W = 6'h25;
  localparam logic [5:0] CFG_UP_ROW_W   = 6'h26;

  function automatic int unsigned lanes_of(
    input int unsigned axi_w,
    input int unsigned data_w
  );
    return axi_w / data_w;
  endfunction

  typedef enum logic [1:0] {
    UP_IDLE,
    UP_PASS,
    UP_REPLAY
  } up_state_t;

endpackage

// File: rtl/upsample_line_buf.sv
// One-row pixel store for vertical replay.
// Single write port, combinational read port.
module upsample_line_buf #(
  parameter int W     = 128,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample_core.sv
// Streaming nearest-neighbour upsampler: first row copy passes
// through, further vertical copies replay from the line buffer.
module upsample_core
  import cnn_cfg_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AXI_WIDTH  = 128,
  parameter int MAX_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 cfg_wr_en,
  input  logic [5:0]           cfg_addr,
  input  logic [63:0]          cfg_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AXI_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AXI_WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int LANES = lanes_of(AXI_WIDTH, DATA_WIDTH);
  localparam int CW    = $clog2(MAX_W);
  localparam int LW    = CW + 1;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] pix_t;

  function automatic logic [2:0] scale_norm(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

  function automatic logic [LW-1:0] rw_norm(input logic [6:0] r);
    if (r == 7'd0)       return LW'(1);
    if (int'(r) > MAX_W) return LW'(MAX_W);
    return LW'(r);
  endfunction

  logic [2:0]    cfg_sh, cfg_sw;
  logic [6:0]    cfg_rw;
  logic [2:0]    sh, sw, hcnt, vrow;
  logic [LW-1:0] rw, row_len;
  logic [CW-1:0] col, rcol;
  logic          done, eor_p;
  pix_t          hold;
  pix_t          lb_rdata;
  up_state_t     state, state_nxt;

  logic free, accept, copy_ld, rep_ld;
  logic eor_in, cp_fin, rep_col_end;
  logic pass_row_end, rep_end, pdone, last_flag;
  logic unused_wdata;

  assign unused_wdata = ^cfg_wdata[63:7];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cfg_sh <= 3'd2;
      cfg_sw <= 3'd2;
      cfg_rw <= 7'd8;
    end else if (cfg_wr_en) begin
      unique case (cfg_addr)
        CFG_UP_SCALE_H: cfg_sh <= cfg_wdata[2:0];
        CFG_UP_SCALE_W: cfg_sw <= cfg_wdata[2:0];
        CFG_UP_ROW_W:   cfg_rw <= cfg_wdata[6:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    free         = !out_valid || out_ready;
    in_ready     = 1'b0;
    copy_ld      = 1'b0;
    rep_ld       = 1'b0;
    eor_in       = ({1'b0, col} == rw - LW'(1)) || in_last;
    cp_fin       = (hcnt == sw - 3'd1);
    rep_col_end  = cp_fin && ({1'b0, rcol} == row_len - LW'(1));
    state_nxt    = state;
    unique case (state)
      UP_PASS: begin
        in_ready = !start && free && !done && !eor_p
                   && (hcnt == 3'd0);
        copy_ld  = !start && free && (hcnt != 3'd0);
      end
      UP_REPLAY: rep_ld = !start && free;
      default: ;
    endcase
    accept       = in_valid && in_ready;
    pdone        = accept ? in_last : done;
    pass_row_end = (accept && eor_in && sw == 3'd1)
                   || (copy_ld && cp_fin && eor_p);
    rep_end      = rep_ld && rep_col_end && (vrow == sh - 3'd1);
    last_flag    = (pass_row_end && pdone && sh == 3'd1)
                   || (rep_end && done);
    // a beat leaving with out_last closes the frame
    unique case (state)
      UP_IDLE: if (start) state_nxt = UP_PASS;
      UP_PASS: begin
        if (start) state_nxt = UP_PASS;
        else if (out_valid && out_ready && out_last)
          state_nxt = UP_IDLE;
        else if (pass_row_end && sh != 3'd1)
          state_nxt = UP_REPLAY;
      end
      UP_REPLAY: begin
        if (start || rep_end) state_nxt = UP_PASS;
      end
      default: state_nxt = UP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= UP_IDLE;
      sh        <= 3'd1;
      sw        <= 3'd1;
      rw        <= LW'(1);
      row_len   <= LW'(1);
      col       <= '0;
      rcol      <= '0;
      hcnt      <= '0;
      vrow      <= '0;
      done      <= 1'b0;
      eor_p     <= 1'b0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        sh        <= scale_norm(cfg_sh);
        sw        <= scale_norm(cfg_sw);
        rw        <= rw_norm(cfg_rw);
        row_len   <= LW'(1);
        col       <= '0;
        rcol      <= '0;
        hcnt      <= '0;
        vrow      <= '0;
        done      <= 1'b0;
        eor_p     <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        hold      <= in_data;
        out_valid <= 1'b1;
        out_last  <= last_flag;
        hcnt      <= (sw == 3'd1) ? 3'd0 : 3'd1;
        done      <= in_last;
        eor_p     <= eor_in && (sw != 3'd1);
        col       <= eor_in ? '0 : col + CW'(1);
        if (eor_in) row_len <= {1'b0, col} + LW'(1);
        if (pass_row_end) vrow <= 3'd1;
      end else if (copy_ld) begin
        out_data  <= hold;
        out_valid <= 1'b1;
        out_last  <= last_flag;
        hcnt      <= cp_fin ? 3'd0 : hcnt + 3'd1;
        if (cp_fin) eor_p <= 1'b0;
        if (pass_row_end) vrow <= 3'd1;
      end else if (rep_ld) begin
        out_data  <= lb_rdata;
        out_valid <= 1'b1;
        out_last  <= last_flag;
        hcnt      <= cp_fin ? 3'd0 : hcnt + 3'd1;
        if (cp_fin) rcol <= rep_col_end ? '0 : rcol + CW'(1);
        if (rep_col_end) vrow <= rep_end ? 3'd0 : vrow + 3'd1;
      end else if (free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  upsample_line_buf #(
    .W     (LANES * DATA_WIDTH),
    .DEPTH (MAX_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (accept),
    .wr_addr (col),
    .wr_data (in_data),
    .rd_addr (rcol),
    .rd_data (lb_rdata)
  );

endmodule

// File: tb/tb_upsample_core.sv
// Directed bench for upsample_core: 2D repeat order, throughput,
// stalls, short rows, abort, cfg corner cases and async reset.
module tb_upsample_core;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic         cfg_wr_en;
  logic [5:0]   cfg_addr;
  logic [63:0]  cfg_wdata;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  int n_chk = 0;
  int n_err = 0;
  int first_c, last_c, n_inrdy;
  logic [127:0] px_q[$];
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  upsample_core dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pix(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic cfg_wr(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build(input int base, input int npix, input int rw,
                       input int sh, input int sw);
    int n;
    px_q.delete();
    exp_q.delete();
    for (int i = 0; i < npix; i++) px_q.push_back(pix(base + i));
    for (int r0 = 0; r0 < npix; r0 += rw) begin
      n = (npix - r0 < rw) ? npix - r0 : rw;
      for (int v = 0; v < sh; v++)
        for (int c = 0; c < n; c++)
          for (int h = 0; h < sw; h++)
            exp_q.push_back(pix(base + r0 + c));
    end
  endtask

  task automatic run_frame(input int last_idx, input int last_beat,
                           input bit rnd, input string tag);
    int idx = 0;
    int k = 0;
    int cyc = 0;
    logic pv_stall = 1'b0;
    logic [127:0] pv_data = '0;
    first_c = -1;
    last_c  = 0;
    n_inrdy = 0;
    while (k < exp_q.size() && cyc < 5000) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (idx < px_q.size());
      in_data   = in_valid ? px_q[idx] : '0;
      in_last   = (idx == last_idx);
      #1;
      if (pv_stall) begin
        chk({tag, "_hold_v"}, 128'(out_valid), 128'(1));
        chk({tag, "_hold_d"}, out_data, pv_data);
      end
      pv_stall = out_valid && !out_ready;
      pv_data  = out_data;
      if (in_ready) n_inrdy++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        chk({tag, "_d"}, out_data, exp_q[k]);
        chk({tag, "_last"}, 128'(out_last), 128'(k == last_beat));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        k++;
      end
      cyc++;
    end
    chk({tag, "_beats"}, 128'(k), 128'(exp_q.size()));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_idle_rdy"}, 128'(in_ready), 128'(0));
    chk({tag, "_idle_v"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int t1 [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
    rst_b     = 1'b0;
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_v", 128'(out_valid), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_d", out_data, 128'(0));
    chk("rst_rdy", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst_b = 1'b1;

    // 2x2 default scales, two rows of two
    cfg_wr(6'h26, 64'd2);
    go();
    px_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) px_q.push_back(pix(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(pix(t1[i]));
    run_frame(3, 15, 1'b0, "t1");
    idle_chk("t1");

    // 3x horizontal only, full rate
    cfg_wr(6'h24, 64'd1);
    cfg_wr(6'h25, 64'd3);
    cfg_wr(6'h26, 64'd4);
    go();
    build(10, 8, 4, 1, 3);
    run_frame(7, 23, 1'b0, "t2");
    chk("t2_span", 128'(last_c - first_c + 1), 128'(24));
    chk("t2_inrdy", 128'(n_inrdy), 128'(8));

    // 4x4 with random backpressure
    cfg_wr(6'h24, 64'd4);
    cfg_wr(6'h25, 64'd4);
    cfg_wr(6'h26, 64'd8);
    go();
    build(100, 8, 8, 4, 4);
    run_frame(7, 127, 1'b1, "t3");

    // short row ends the frame early
    cfg_wr(6'h24, 64'd2);
    cfg_wr(6'h25, 64'd2);
    go();
    build(30, 3, 8, 2, 2);
    run_frame(2, 11, 1'b0, "t4");
    idle_chk("t4");

    // abort in the middle of a replay
    cfg_wr(6'h26, 64'd2);
    go();
    px_q.delete();
    exp_q.delete();
    px_q.push_back(pix(20));
    px_q.push_back(pix(21));
    exp_q.push_back(pix(20));
    exp_q.push_back(pix(20));
    exp_q.push_back(pix(21));
    exp_q.push_back(pix(21));
    exp_q.push_back(pix(20));
    run_frame(-1, -1, 1'b0, "t5a");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("t5_abort_v", 128'(out_valid), 128'(0));
    build(50, 4, 2, 2, 2);
    run_frame(3, 15, 1'b0, "t5b");

    // zero scales act as 1x1
    cfg_wr(6'h24, 64'd0);
    cfg_wr(6'h25, 64'd0);
    cfg_wr(6'h26, 64'd3);
    go();
    build(70, 3, 3, 1, 1);
    run_frame(2, 2, 1'b0, "t6a");

    // start latches the value before a same-cycle write
    cfg_wr(6'h24, 64'd2);
    cfg_wr(6'h26, 64'd4);
    @(negedge clk);
    start     = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_addr  = 6'h26;
    cfg_wdata = 64'd2;
    @(negedge clk);
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    build(40, 4, 4, 2, 1);
    run_frame(3, 7, 1'b0, "t6b");
    go();
    build(40, 4, 2, 2, 1);
    run_frame(3, 7, 1'b0, "t6c");

    // async reset with a stalled beat pending
    cfg_wr(6'h25, 64'd2);
    go();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = pix(60);
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("t7_pre_v", 128'(out_valid), 128'(1));
    #1;
    rst_b = 1'b0;
    #1;
    chk("t7_v", 128'(out_valid), 128'(0));
    chk("t7_last", 128'(out_last), 128'(0));
    chk("t7_d", out_data, 128'(0));
    chk("t7_rdy", 128'(in_ready), 128'(0));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_b     = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
